keypad_responder: RTL and testbench
===================================

Name: keypad_responder

Overview:
- Behavioural/synthesizable keypad emulator: the responder end of the 4x4 row-scan keypad interface.
- Watches the scanner's active-low one-hot keypadRow and drives keypadCol as if a physical key were held.
- Key events are injected through a valid/ready port and held for a programmable number of full scan rounds, then released.
- Used for board-level self-test and for bench stimulus of the keypad scanner / dot-matrix display path.

Parameters:
HOLD_SCANS, 2, number of complete scan rounds the key reads as pressed (0 treated as 1)
RELEASE_SCANS, 2, number of complete scan rounds forced released before the next key is accepted (0 treated as 1)
CNT_W, 8, width of the scan-round counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
keypadRow  in  4  row strobe from scanner, one-hot active-low (1110,1101,1011,0111)
keypadCol  out  4  column return to scanner, active-low; 1111 = no key
key_code  in  4  hex key to press (0-F)
key_valid  in  1  key_code valid
key_ready  out  1  high when a new key can be accepted
key_pressed  out  1  high while the key is being presented
scan_err  out  1  sticky flag: keypadRow seen with an illegal pattern

Behaviour:
- Reset (rst low, async): keypadCol=1111, key_ready=1, key_pressed=0, scan_err=0, state=IDLE, counters=0, stored key=0.
- Key map (row pattern, col pattern -> key):
  - Row 1110: col 1110=7, 1101=4, 1011=1, 0111=0.
  - Row 1101: 8, 5, 2, A.
  - Row 1011: 9, 6, 3, B.
  - Row 0111: C, D, E, F.
- Accept: on a clk edge with key_valid & key_ready, latch key_code, go IDLE->ARM. key_ready is high only in IDLE. key_valid while not ready is ignored; no queueing.
- Wrap detect: registered prev_row. wrap = (keypadRow==1110) && (prev_row!=1110). One pulse per scan round.
- State machine:
  - IDLE: wait for accept.
  - ARM: wait for the first wrap, so the press begins on a round boundary. Then go to PRESS with cnt=0.
  - PRESS: key_pressed=1. Each wrap increments cnt. When cnt reaches max(HOLD_SCANS,1), go to RELEASE with cnt=0, on the same edge as that wrap.
  - RELEASE: keypadCol forced 1111. Each wrap increments cnt. At max(RELEASE_SCANS,1) go to IDLE.
- Column drive: registered, 1-cycle latency. keypadCol <= (state==PRESS && keypadRow==target_row) ? target_col : 1111. Otherwise 1111.
- Latency is negligible against the scanner's sampling period (>=500000 cycles per row).
- Illegal row (any value not in the 4 legal patterns):
  - keypadCol <= 1111 and scan_err <= 1, sticky until reset.
  - Not counted as a wrap. prev_row still updates.
- Stalled scanner (row constant): the FSM holds its state indefinitely; no timeout.
- key_valid in the same cycle as the RELEASE->IDLE transition is not accepted; it is accepted on the next cycle.
- Reset mid-press: immediate return to reset values; keypadCol is 1111 asynchronously.
- Counter saturates at 2^CNT_W-1; parameters must be below that.

Decomposition:
- Shared package keypad_pkg:
  - row/col pattern constants ROW0..ROW3, COL0..COL3, NO_KEY=1111.
  - Function key_to_rowcol(code) returning {row,col}.
  - Function row_legal(row).
  - The same table is reused by the scanner decode and the bench scoreboard.
- One sub-module scan_wrap_detect: prev_row register, wrap pulse and illegal-pattern flag.

Test Plan:
- Reset, then a model scanner cycling rows every 8 clk; inject key_code=5 -> keypadCol=1101 only in cycles following row=1101, for exactly 2 rounds. Then 1111 for 2 rounds, then key_ready=1.
- Sweep all 16 codes 0-F through the model scanner with the reference decode table -> decoded key equals injected code for every code.
- key_valid held high with codes 3 then C back-to-back -> second accepted only after RELEASE completes. Scanner sees 3 then C, separated by >=2 rounds of 1111.
- Force keypadRow=1100 for one cycle mid-PRESS -> scan_err=1 and stays 1, keypadCol=1111 that cycle, round count unchanged (press lasts exactly 2 legal wraps).
- Assert rst low mid-PRESS of key F -> keypadCol=1111 immediately, key_ready=1, key_pressed=0. After release of reset, the next key presses normally.
- HOLD_SCANS=0, RELEASE_SCANS=0 -> behaves as 1 round each; scanner frozen at 1011 -> state holds in PRESS, no spurious wrap.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: row/column strobe patterns, FSM encodings and the
// hex-key to row/column map used by the responder.
package keypad_pkg;

  localparam logic [3:0] ROW0   = 4'b1110;
  localparam logic [3:0] ROW1   = 4'b1101;
  localparam logic [3:0] ROW2   = 4'b1011;
  localparam logic [3:0] ROW3   = 4'b0111;
  localparam logic [3:0] COL0   = 4'b1110;
  localparam logic [3:0] COL1   = 4'b1101;
  localparam logic [3:0] COL2   = 4'b1011;
  localparam logic [3:0] COL3   = 4'b0111;
  localparam logic [3:0] NO_KEY = 4'b1111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_PRESS   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } rowcol_t;

  function automatic rowcol_t key_to_rowcol(input logic [3:0] code);
    rowcol_t rc;
    rc = '{row: NO_KEY, col: NO_KEY};
    case (code)
      4'h7: rc = '{row: ROW0, col: COL0};
      4'h4: rc = '{row: ROW0, col: COL1};
      4'h1: rc = '{row: ROW0, col: COL2};
      4'h0: rc = '{row: ROW0, col: COL3};
      4'h8: rc = '{row: ROW1, col: COL0};
      4'h5: rc = '{row: ROW1, col: COL1};
      4'h2: rc = '{row: ROW1, col: COL2};
      4'hA: rc = '{row: ROW1, col: COL3};
      4'h9: rc = '{row: ROW2, col: COL0};
      4'h6: rc = '{row: ROW2, col: COL1};
      4'h3: rc = '{row: ROW2, col: COL2};
      4'hB: rc = '{row: ROW2, col: COL3};
      4'hC: rc = '{row: ROW3, col: COL0};
      4'hD: rc = '{row: ROW3, col: COL1};
      4'hE: rc = '{row: ROW3, col: COL2};
      default: rc = '{row: ROW3, col: COL3};
    endcase
    return rc;
  endfunction

  function automatic logic row_legal(input logic [3:0] row);
    return row inside {ROW0, ROW1, ROW2, ROW3};
  endfunction

endpackage

// File: rtl/keypad_responder_scan_wrap_detect.sv
// Tracks the previous row strobe and flags the start of each scan round
// (entry into ROW0) as well as any non-one-hot row pattern.
module scan_wrap_detect
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_row,
  output logic       o_wrap,
  output logic       o_illegal
);

  logic [3:0] r_prev_row;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev_row <= NO_KEY;
    else      r_prev_row <= i_row;
  end

  assign o_illegal = !row_legal(i_row);
  assign o_wrap    = (i_row == ROW0) && (r_prev_row != ROW0);

endmodule

// File: rtl/keypad_responder.sv
// Keypad responder: emulates a held key on a 4x4 row-scanned keypad for a
// programmable number of scan rounds, then forces a release interval.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS    = 2,
  parameter int RELEASE_SCANS = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypadRow,
  output logic [3:0] keypadCol,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       key_pressed,
  output logic       scan_err
);

  localparam int HOLD_LIM = (HOLD_SCANS < 1) ? 1 : HOLD_SCANS;
  localparam int REL_LIM  = (RELEASE_SCANS < 1) ? 1 : RELEASE_SCANS;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_LIM);
  localparam logic [CNT_W-1:0] REL_MAX  = CNT_W'(REL_LIM);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key;
  logic [3:0]       r_col;
  logic             r_err;

  logic             w_wrap;
  logic             w_illegal;
  logic [CNT_W-1:0] w_cnt_inc;
  rowcol_t          w_target;

  scan_wrap_detect u_wrap (
    .clk       (clk),
    .rst       (rst),
    .i_row     (keypadRow),
    .o_wrap    (w_wrap),
    .o_illegal (w_illegal)
  );

  assign w_target  = key_to_rowcol(r_key);
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (key_valid) begin
            r_key   <= key_code;
            r_state <= ST_ARM;
          end
        end
        // Hold off until a round boundary so the press spans whole rounds.
        ST_ARM: begin
          if (w_wrap) begin
            r_state <= ST_PRESS;
            r_cnt   <= '0;
          end
        end
        ST_PRESS: begin
          if (w_wrap) begin
            if (w_cnt_inc >= HOLD_MAX) begin
              r_state <= ST_RELEASE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          if (w_wrap) begin
            if (w_cnt_inc >= REL_MAX) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= NO_KEY;
      r_err <= 1'b0;
    end else begin
      if (w_illegal) begin
        r_col <= NO_KEY;
        r_err <= 1'b1;
      end else if (r_state == ST_PRESS && keypadRow == w_target.row) begin
        r_col <= w_target.col;
      end else begin
        r_col <= NO_KEY;
      end
    end
  end

  assign keypadCol   = r_col;
  assign scan_err    = r_err;
  assign key_ready   = (r_state == ST_IDLE);
  assign key_pressed = (r_state == ST_PRESS);

endmodule

// File: tb/tb_keypad_responder.sv
// Bench for keypad_responder: a model row scanner decodes presented keys and a
// scoreboard compares each completed press against the queued expectation.
module tb_keypad_responder;

  typedef struct {
    logic [3:0] code;
    int         len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row, col, code;
  logic       valid, ready, pressed, err;
  logic [3:0] row2, col2, code2;
  logic       valid2, ready2, pressed2, err2;

  always #5 clk = ~clk;

  keypad_responder #(.HOLD_SCANS(2), .RELEASE_SCANS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .keypadRow(row), .keypadCol(col),
    .key_code(code), .key_valid(valid), .key_ready(ready),
    .key_pressed(pressed), .scan_err(err)
  );

  keypad_responder #(.HOLD_SCANS(0), .RELEASE_SCANS(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .keypadRow(row2), .keypadCol(col2),
    .key_code(code2), .key_valid(valid2), .key_ready(ready2),
    .key_pressed(pressed2), .scan_err(err2)
  );

  // Reference keypad: row strobes and key at [row index][column index].
  logic [3:0] ROWS [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] KEYMAP [4][4] = '{'{4'h7, 4'h4, 4'h1, 4'h0},
                                '{4'h8, 4'h5, 4'h2, 4'hA},
                                '{4'h9, 4'h6, 4'h3, 4'hB},
                                '{4'hC, 4'hD, 4'hE, 4'hF}};

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  int idx = 3, sub = 0, round_cnt = 0, round_obs = 16;
  int run_len = 0, run_code = 0, gap = 0, gate_viol = 0;
  bit have_prev = 0, mon_clear = 0, scan_on = 0;
  bit glitch_req = 0, glitch_chk = 0, glitch_done = 0;
  logic [3:0] exp_row = 4'hF, exp_col = 4'hF;
  int acc_cnt = 0, last_acc_round = 0, prev_acc_round = 0;
  logic [3:0] last_acc_code = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int col_index(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic process_round(input int obs);
    check("round_clean", 32'(obs <= 16), 1);
    if (obs < 16) begin
      if (run_len == 0) begin
        if (have_prev) check("gap_ge_2_rounds", 32'(gap >= 2), 1);
        run_code = obs;
        run_len  = 1;
      end else begin
        check("code_stable", obs, run_code);
        run_len++;
      end
    end else if (obs == 16) begin
      if (run_len > 0) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("press_code", run_code, 32'(e.code));
          check("press_rounds", run_len, e.len);
        end
        run_len   = 0;
        gap       = 1;
        have_prev = 1;
      end else begin
        gap++;
      end
    end
  endtask

  // Model scanner + monitor: rows advance every 8 clk, columns sampled late in each row.
  always @(negedge clk) begin
    if (mon_clear) begin
      sb_q.delete();
      run_len = 0; gap = 0; have_prev = 0; round_obs = 16; mon_clear = 0;
    end
    if (col !== 4'hF && !(row == exp_row && col == exp_col)) gate_viol++;
    if (glitch_chk) begin
      check("glitch_col_released", 32'(col), 32'hF);
      check("glitch_scan_err", 32'(err), 1);
      glitch_chk = 0;
    end
    if (scan_on && sub == 7) begin
      if (col !== 4'hF) begin
        int ci;
        ci = col_index(col);
        if (ci < 0 || round_obs != 16) round_obs = 17;
        else round_obs = int'(KEYMAP[idx][ci]);
      end
      if (idx == 3) begin
        process_round(round_obs);
        round_obs = 16;
      end
    end
    if (scan_on) begin
      sub++;
      if (sub == 8) begin
        sub = 0;
        idx = (idx + 1) % 4;
        if (idx == 0) round_cnt++;
      end
    end
    if (glitch_req && idx == 2 && sub == 3) begin
      row = 4'b1100;
      glitch_req = 0; glitch_chk = 1; glitch_done = 1;
    end else begin
      row = ROWS[idx];
    end
  end

  // Handshake watcher: tracks the accepted key for column-gating and round counts.
  always @(posedge clk) begin
    if (rst && valid && ready) begin
      acc_cnt++;
      last_acc_code  = code;
      prev_acc_round = last_acc_round;
      last_acc_round = round_cnt;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (KEYMAP[r][c] == code) begin
            exp_row = ROWS[r];
            exp_col = ROWS[c];
          end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_key(input logic [3:0] c, input int len);
    int t;
    t = 0;
    while (!ready && t < 2000) begin tick(1); t++; end
    check("ready_before_send", 32'(ready), 1);
    sb_q.push_back('{code: c, len: len});
    code  = c;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(ready && sb_q.size() == 0) && t < 3000) begin tick(1); t++; end
    check("drain_in_budget", 32'(ready && sb_q.size() == 0), 1);
  endtask

  task automatic wait_pressed();
    int t;
    t = 0;
    while (!pressed && t < 1000) begin tick(1); t++; end
    check("press_started", 32'(pressed), 1);
  endtask

  task automatic set_row2(input logic [3:0] r, input int n);
    row2 = r;
    tick(n);
  endtask

  initial begin
    int rc0, t, a0;
    row = 4'b0111; row2 = 4'b0111;
    code = 4'h0; valid = 1'b0; code2 = 4'h0; valid2 = 1'b0;
    rst = 1'b0;
    scan_on = 1;
    tick(3);
    check("rst_col", 32'(col), 32'hF);
    check("rst_ready", 32'(ready), 1);
    check("rst_pressed", 32'(pressed), 0);
    check("rst_err", 32'(err), 0);
    check("rst_col2", 32'(col2), 32'hF);
    rst = 1'b1;
    tick(2);

    // Key 5: two pressed rounds, two released rounds, then ready.
    send_key(4'h5, 2);
    rc0 = round_cnt;
    check("busy_after_accept", 32'(ready), 0);
    wait_pressed();
    t = 0;
    while (!ready && t < 2000) begin tick(1); t++; end
    check("ready_after_5_rounds", round_cnt - rc0, 5);
    wait_idle();

    // Sweep every hex key through the scanner decode.
    for (int k = 0; k < 16; k++) begin
      send_key(4'(k), 2);
      wait_idle();
    end

    // key_valid held high across 3 then C.
    sb_q.push_back('{code: 4'h3, len: 2});
    sb_q.push_back('{code: 4'hC, len: 2});
    a0 = acc_cnt;
    code = 4'h3; valid = 1'b1;
    t = 0;
    while (acc_cnt == a0 && t < 100) begin tick(1); t++; end
    check("b2b_first_code", 32'(last_acc_code), 32'h3);
    code = 4'hC;
    t = 0;
    while (acc_cnt == a0 + 1 && t < 2000) begin tick(1); t++; end
    valid = 1'b0;
    check("b2b_second_code", 32'(last_acc_code), 32'hC);
    check("b2b_rounds_between", last_acc_round - prev_acc_round, 5);
    wait_idle();

    // Illegal row mid-press of key 6.
    check("err_clear_before", 32'(err), 0);
    send_key(4'h6, 2);
    wait_pressed();
    glitch_req = 1;
    t = 0;
    while (!glitch_done && t < 200) begin tick(1); t++; end
    check("glitch_issued", 32'(glitch_done), 1);
    wait_idle();
    check("err_sticky", 32'(err), 1);

    // Reset in the middle of key F.
    send_key(4'hF, 2);
    wait_pressed();
    t = 0;
    while (!(idx == 3 && sub >= 3) && t < 200) begin tick(1); t++; end
    check("f_presented", 32'(col), 32'b0111);
    rst = 1'b0;
    mon_clear = 1;
    #1;
    check("midrst_col", 32'(col), 32'hF);
    check("midrst_ready", 32'(ready), 1);
    check("midrst_pressed", 32'(pressed), 0);
    check("midrst_err", 32'(err), 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    send_key(4'h2, 2);
    wait_idle();

    // HOLD_SCANS=0 / RELEASE_SCANS=0 instance with a hand-driven, frozen scanner.
    check("d0_ready", 32'(ready2), 1);
    code2 = 4'h6; valid2 = 1'b1;
    tick(1);
    valid2 = 1'b0;
    check("d0_armed_busy", 32'(ready2), 0);
    set_row2(4'b1101, 4);
    set_row2(4'b1011, 4);
    set_row2(4'b0111, 4);
    check("d0_arm_waits", 32'(pressed2), 0);
    set_row2(4'b1110, 4);
    check("d0_press_on_wrap", 32'(pressed2), 1);
    set_row2(4'b1101, 4);
    check("d0_other_row", 32'(col2), 32'hF);
    set_row2(4'b1011, 200);
    check("d0_frozen_pressed", 32'(pressed2), 1);
    check("d0_frozen_col", 32'(col2), 32'b1101);
    set_row2(4'b0111, 4);
    check("d0_no_spurious", 32'(pressed2), 1);
    set_row2(4'b1110, 4);
    check("d0_release", 32'(pressed2), 0);
    check("d0_release_busy", 32'(ready2), 0);
    set_row2(4'b1101, 4);
    set_row2(4'b1011, 4);
    check("d0_release_col", 32'(col2), 32'hF);
    set_row2(4'b0111, 4);
    check("d0_still_release", 32'(ready2), 0);
    set_row2(4'b1110, 4);
    check("d0_idle", 32'(ready2), 1);
    check("d0_no_err", 32'(err2), 0);

    check("col_gating_violations", gate_viol, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
